// File: rtl/sevenseg_reader.sv
// Recovers a 16-bit hex value from a multiplexed 4-digit common-anode 7-segment bus.
// Each digit must hold steady for SETTLE edges before capture; Valid pulses per full frame.

module sevenseg_digit_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       clr_cap,
  input  logic [3:0] nib_in,
  output logic [3:0] nib,
  output logic       cap
);
  logic [3:0] nib_q, nib_d;
  logic       cap_q, cap_d;

  always_comb begin
    nib_d = nib_q;
    cap_d = cap_q;
    if (wr_en) begin
      nib_d = nib_in;
      cap_d = 1'b1;
    end
    // a completing capture also lands here, but the frame is closed on the same edge
    if (clr_cap) cap_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_q <= 4'h0;
      cap_q <= 1'b0;
    end else begin
      nib_q <= nib_d;
      cap_q <= cap_d;
    end
  end

  assign nib = nib_q;
  assign cap = cap_q;
endmodule

module sevenseg_reader #(
  parameter int SETTLE = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [6:0]  Seg,
  input  logic [3:0]  An,
  output logic [15:0] Value,
  output logic        Valid,
  output logic        FrameErr,
  output logic [3:0]  Captured
);
  localparam int NUM_DIG = 4;
  localparam int CW      = $clog2(SETTLE + 1);
  localparam logic [10:0] BLANK = 11'h7FF;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } sample_t;

  // {err, nibble}; err set for any pattern outside the hex glyph set
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'b0111111: seg_decode = 5'h00;
      7'b0000110: seg_decode = 5'h01;
      7'b1011011: seg_decode = 5'h02;
      7'b1001111: seg_decode = 5'h03;
      7'b1100110: seg_decode = 5'h04;
      7'b1101101: seg_decode = 5'h05;
      7'b1111101: seg_decode = 5'h06;
      7'b0000111: seg_decode = 5'h07;
      7'b1111111: seg_decode = 5'h08;
      7'b1101111: seg_decode = 5'h09;
      7'b1110111: seg_decode = 5'h0A;
      7'b1111100: seg_decode = 5'h0B;
      7'b0111001: seg_decode = 5'h0C;
      7'b1011110: seg_decode = 5'h0D;
      7'b1111001: seg_decode = 5'h0E;
      7'b1110001: seg_decode = 5'h0F;
      default:    seg_decode = 5'h10;
    endcase
  endfunction

  sample_t       smp_q, smp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   value_q, value_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          acc_q, acc_d;

  logic                      same;
  logic [NUM_DIG-1:0]        sel;
  logic                      cap_fire;
  logic                      done;
  logic [4:0]                dec;
  logic [NUM_DIG-1:0]        wr_en;
  logic [NUM_DIG-1:0]        cap_vec;
  logic [NUM_DIG-1:0][3:0]   nib;
  logic [NUM_DIG-1:0][3:0]   frame;

  assign smp_d = sample_t'({An, Seg});
  assign same  = (smp_d == smp_q);
  assign sel   = ~smp_q.an;
  assign dec   = seg_decode(~smp_q.seg);

  // the transition into saturation is the single capture point for a held pattern
  assign cap_fire = same && (cnt_q == CW'(SETTLE - 1)) && $onehot(sel);
  assign wr_en    = cap_fire ? sel : '0;
  assign done     = cap_fire && ((cap_vec | sel) == 4'hF);

  always_comb begin
    cnt_d = cnt_q;
    if (!same)                        cnt_d = '0;
    else if (cnt_q != CW'(SETTLE))    cnt_d = CW'(cnt_q + 1'b1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
      sevenseg_digit_slot u_slot (
        .clk     (Clock),
        .rst     (Reset),
        .wr_en   (wr_en[gi]),
        .clr_cap (done),
        .nib_in  (dec[3:0]),
        .nib     (nib[gi]),
        .cap     (cap_vec[gi])
      );
      // shadow contents with the completing digit merged in for the same-edge load
      assign frame[gi] = sel[gi] ? dec[3:0] : nib[gi];
    end
  endgenerate

  always_comb begin
    value_d = value_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    acc_d   = acc_q;
    if (cap_fire) acc_d = acc_q | dec[4];
    if (done) begin
      value_d = frame;
      ferr_d  = acc_q | dec[4];
      valid_d = 1'b1;
      acc_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      smp_q   <= sample_t'(BLANK);
      cnt_q   <= '0;
      value_q <= 16'h0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      acc_q   <= acc_d;
    end
  end

  assign Value    = value_q;
  assign Valid    = valid_q;
  assign FrameErr = ferr_q;
  assign Captured = cap_vec;
endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader: run-length/frame model checked every cycle plus literal frame checks.

module tb_sevenseg_reader;
  localparam int SETTLE = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [6:0]  Seg;
  logic [3:0]  An;
  logic [15:0] Value;
  logic        Valid;
  logic        FrameErr;
  logic [3:0]  Captured;

  sevenseg_reader #(.SETTLE(SETTLE)) dut (
    .Clock(Clock), .Reset(Reset), .Seg(Seg), .An(An),
    .Value(Value), .Valid(Valid), .FrameErr(FrameErr), .Captured(Captured)
  );

  always #5 Clock = ~Clock;

  int vecs = 0;
  int errs = 0;
  int vcnt = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyph table in active-high g..a order; index is the hex digit.
  logic [6:0] glyph [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Model: a pattern is captured when it has been seen on exactly SETTLE+1 consecutive edges.
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_cap;
  logic        m_acc;
  logic [15:0] m_value;
  logic        m_valid, m_ferr;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_prev = 11'h7FF; m_run = 1;
      for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
      m_cap = 4'h0; m_acc = 0; m_value = 16'h0; m_valid = 0; m_ferr = 0;
    end else begin
      logic [10:0] cur;
      cur = {An, Seg};
      m_valid = 0;
      if (cur == m_prev) m_run++; else m_run = 1;
      m_prev = cur;
      if (m_run == SETTLE + 1 && $countones(~An) == 1) begin
        int d; int nibv; bit bad;
        d = 0;
        for (int i = 0; i < 4; i++) if (!An[i]) d = i;
        nibv = 0; bad = 1;
        for (int g = 0; g < 16; g++) if (glyph[g] == ~Seg) begin nibv = g; bad = 0; end
        m_shadow[d] = nibv[3:0];
        m_cap[d] = 1'b1;
        m_acc = m_acc | bad;
        if (m_cap == 4'hF) begin
          m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
          m_ferr = m_acc; m_valid = 1; m_cap = 4'h0; m_acc = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clock);
      if (chk_en) begin
        chk("model_value", Value, m_value);
        chk("model_valid", Valid, m_valid);
        chk("model_ferr", FrameErr, m_ferr);
        chk("model_captured", Captured, m_cap);
        if (Valid === 1'b1) vcnt++;
      end
    end
  end

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    An = an; Seg = seg;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic scan(input logic [6:0] s0, s1, s2, s3);
    show(4'b1110, s0, 8);
    show(4'b1101, s1, 8);
    show(4'b1011, s2, 8);
    show(4'b0111, s3, 8);
    show(4'b1111, 7'h7F, 3);
  endtask

  // active-low segment drives
  localparam logic [6:0] S_F = ~7'b1110001, S_3 = ~7'b1001111, S_A = ~7'b1110111;
  localparam logic [6:0] S_1 = ~7'b0000110, S_7 = ~7'b0000111, S_BAD = ~7'b1010101;

  initial begin
    Reset = 1; An = 4'hF; Seg = 7'h7F;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_value", Value, 16'h0);
    chk("rst_valid", Valid, 1'b0);
    chk("rst_ferr", FrameErr, 1'b0);
    chk("rst_captured", Captured, 4'h0);
    Reset = 0; chk_en = 1;

    // clean frame
    vcnt = 0;
    scan(S_F, S_3, S_A, S_1);
    chk("f1_value", Value, 16'h1A3F);
    chk("f1_ferr", FrameErr, 1'b0);
    chk("f1_captured", Captured, 4'h0);
    chk("f1_nvalid", vcnt, 1);

    // bad glyph on digit 2, then a clean frame clears the error
    vcnt = 0;
    scan(S_F, S_3, S_BAD, S_1);
    chk("f2_value", Value, 16'h103F);
    chk("f2_ferr", FrameErr, 1'b1);
    scan(S_F, S_3, S_A, S_1);
    chk("f3_ferr", FrameErr, 1'b0);
    chk("f3_nvalid", vcnt, 2);

    // glitch shorter than settle time
    vcnt = 0;
    show(4'b1110, S_F, 3);
    show(4'b1111, 7'h7F, 6);
    chk("glitch_captured", Captured, 4'h0);
    chk("glitch_nvalid", vcnt, 0);

    // digit 1 rescanned before completion
    vcnt = 0;
    show(4'b1110, S_F, 8);
    show(4'b1101, S_3, 8);
    show(4'b1011, S_A, 8);
    show(4'b1101, S_7, 8);
    chk("rescan_partial", Captured, 4'b0111);
    show(4'b0111, S_1, 8);
    show(4'b1111, 7'h7F, 3);
    chk("rescan_value", Value, 16'h1A7F);
    chk("rescan_nvalid", vcnt, 1);

    // two anodes low: ignored
    show(4'b1110, S_F, 8);
    show(4'b1100, S_3, 10);
    show(4'b1111, 7'h7F, 4);
    chk("multi_an_captured", Captured, 4'b0001);
    chk("multi_an_ferr", FrameErr, 1'b0);

    // reset with a partial frame pending
    show(4'b1101, S_3, 8);
    chk("pre_rst_captured", Captured, 4'b0011);
    Reset = 1;
    #1;
    chk("mid_rst_value", Value, 16'h0);
    chk("mid_rst_captured", Captured, 4'h0);
    chk("mid_rst_valid", Valid, 1'b0);
    chk("mid_rst_ferr", FrameErr, 1'b0);
    @(posedge Clock); #1;
    Reset = 0;
    vcnt = 0;
    scan(S_F, S_3, S_A, S_1);
    chk("post_rst_value", Value, 16'h1A3F);
    chk("post_rst_nvalid", vcnt, 1);

    // long hold: no recapture while saturated, frame still completes once
    vcnt = 0;
    show(4'b1110, S_A, 30);
    show(4'b1101, S_A, 5);
    show(4'b1011, S_A, 5);
    show(4'b0111, S_A, 5);
    show(4'b1111, 7'h7F, 3);
    chk("hold_value", Value, 16'hAAAA);
    chk("hold_nvalid", vcnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
